mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
Arbitrates the shared memory port among three masters: M1 (index 0), M2 (index 1) and M3 (index 2).
- M1 has absolute priority and may preempt M2 or M3.
- M2 and M3 share access by round-robin.
- A hold-cycle limit forces an owner to release when others are waiting.
- Grants, preemptions and timeouts are reported to the memory datapath and to status logic.

Parameters:
MAX_HOLD, 4, maximum consecutive granted cycles before forced release when another master is requesting (legal range 2..15).
CNT_W, 16, width of the event counters.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req  input  3  per-master request; bit0=M1, bit1=M2, bit2=M3.
done  input  3  per-master completion; sampled only for the current owner.
gnt  output  3  one-hot grant, registered; all-zero when idle.
accmodule  output  2  00 idle, 01 M1, 10 M2, 11 M3; always consistent with gnt.
busy  output  1  high whenever gnt is non-zero.
nb_preempts  output  CNT_W  count of M1 preemptions; saturates at all-ones.
nb_timeouts  output  CNT_W  count of forced releases; saturates at all-ones.

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on port reset.
- On reset: gnt=000, accmodule=00, busy=0, nb_preempts=0, nb_timeouts=0, hold_cnt=0, resume=none, rr_last=M3 (so M2 wins the first M2/M3 contest).
- Reset asserted mid-grant drops gnt in the next cycle; no counter increments in that cycle.

State machine (IDLE, OWN):
- IDLE, req=000: stay IDLE.
- IDLE, req!=000: select a winner; gnt is asserted on the next clock. Request-to-grant latency is 1 cycle.
- OWN: hold_cnt=1 in the first granted cycle and increments each further cycle. It saturates at MAX_HOLD and resets on every new grant.

Winner selection, highest first:
1. M1 if req[0].
2. The resume master, if its req bit is still set.
3. Of M2/M3, the one not equal to rr_last. If only one is requesting, that one wins.
- rr_last updates whenever M2 or M3 receives a grant.

Release, evaluated in OWN each cycle:
- Normal release: done[owner]=1, or req[owner]=0 (abandon).
  - The next cycle grants a new winner from the current req, which may include the owner; zero-gap back-to-back.
  - If req=000, next state is IDLE.
- Preemption: owner is M2 or M3, req[0]=1, no normal release.
  - Next cycle gnt=001 and nb_preempts increments.
  - resume is set to the preempted master and cleared when that master is granted or deasserts req.
  - M1 cannot be preempted.
- Timeout: hold_cnt==MAX_HOLD, no normal release, another master (excluding the owner) is requesting.
  - Next cycle grants the winner among the others and nb_timeouts increments.
  - A timed-out M2/M3 is not recorded in resume.
  - With no other requester, the owner keeps the grant indefinitely.

Simultaneous events:
- done with req[0]: normal release; M1 wins by priority; not counted as a preemption.
- Preemption and timeout in the same cycle: counted as a preemption only.
- done bits of non-owners and done during IDLE are ignored.

Invariants:
- gnt is one-hot or zero.
- gnt[i] is only ever granted when req[i] was high in the previous cycle.

Test Plan:
- Reset, then req=010 held for 2 cycles, then done=010 -> gnt=010 and accmodule=10 from cycle 1; gnt=000 and busy=0 one cycle after done.
- req=110 held, each owner asserts done after 1 cycle -> grants alternate 010, 100, 010, 100 with no idle gap; counters stay 0.
- M3 owns, req[0] rises with done=000 -> next cycle gnt=001, nb_preempts=1. M1 done with req=110 -> gnt=100 (resume beats round-robin).
- M2 owns with done=0 and req=110 for MAX_HOLD=4 cycles -> cycle 5 gnt=100, nb_timeouts=1. With req=010 only, M2 holds for 10 cycles with no timeout.
- Owner M2 asserts done in the same cycle req[0] rises -> gnt=001, nb_preempts unchanged. Reset asserted during an M1 grant -> next cycle gnt=000 and counters 0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Shared memory port arbiter for three masters: M1 has absolute priority and may
// preempt, M2/M3 alternate round-robin, and a hold limit forces release under contention.
module mem_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  output logic [2:0]       gnt,
  output logic [1:0]       accmodule,
  output logic             busy,
  output logic [CNT_W-1:0] nb_preempts,
  output logic [CNT_W-1:0] nb_timeouts
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  localparam logic [3:0]       HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [2:0] resume;   // one-hot preempted master waiting to resume, 0 = none
  logic       rr_last;  // 1 = M3 was the last M2/M3 granted, 0 = M2

  logic [2:0] others;
  logic       normal_rel;
  logic       preempt;
  logic       timeout;
  logic       new_grant;
  logic [2:0] next_gnt;

  function automatic logic [2:0] pick(input logic [2:0] r, input logic [2:0] res,
                                      input logic last_m3);
    if (r[0]) return 3'b001;
    if ((r & res) != 3'b000) return res;
    if (r[1] && r[2]) return last_m3 ? 3'b010 : 3'b100;
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    others     = req & ~gnt;
    normal_rel = (state == OWN) && ((gnt & (done | ~req)) != 3'b000);
    preempt    = (state == OWN) && !normal_rel && !gnt[0] && req[0];
    timeout    = (state == OWN) && !normal_rel && !preempt &&
                 (hold_cnt == HOLD_MAX) && (others != 3'b000);
    next_gnt   = gnt;
    new_grant  = 1'b0;
    if (state == IDLE || normal_rel) begin
      next_gnt  = pick(req, resume, rr_last);
      new_grant = (req != 3'b000);
    end else if (preempt) begin
      next_gnt  = 3'b001;
      new_grant = 1'b1;
    end else if (timeout) begin
      next_gnt  = pick(others, resume, rr_last);
      new_grant = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 3'b000;
      hold_cnt    <= 4'd0;
      resume      <= 3'b000;
      rr_last     <= 1'b1;
      nb_preempts <= '0;
      nb_timeouts <= '0;
    end else begin
      gnt   <= next_gnt;
      state <= (next_gnt != 3'b000) ? OWN : IDLE;

      if (next_gnt == 3'b000)     hold_cnt <= 4'd0;
      else if (new_grant)         hold_cnt <= 4'd1;
      else if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 4'd1;

      if (new_grant && (next_gnt[1] || next_gnt[2])) rr_last <= next_gnt[2];

      // A timed-out owner is deliberately not remembered; only preemption arms resume.
      if (preempt)
        resume <= gnt;
      else if ((new_grant && next_gnt == resume) || ((resume & ~req) != 3'b000))
        resume <= 3'b000;

      if (preempt && nb_preempts != CNT_SAT) nb_preempts <= nb_preempts + 1'b1;
      if (timeout && nb_timeouts != CNT_SAT) nb_timeouts <= nb_timeouts + 1'b1;
    end
  end

  always_comb begin
    unique case (gnt)
      3'b001:  accmodule = 2'b01;
      3'b010:  accmodule = 2'b10;
      3'b100:  accmodule = 2'b11;
      default: accmodule = 2'b00;
    endcase
  end

  assign busy = (gnt != 3'b000);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed and randomized bench for mem_rr_arbiter, checked against an
// index-based reference model of the arbitration rules.
module tb_mem_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req;
  logic [2:0]       done;
  logic [2:0]       gnt;
  logic [1:0]       accmodule;
  logic             busy;
  logic [CNT_W-1:0] nb_preempts;
  logic [CNT_W-1:0] nb_timeouts;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner/resume are master indices, -1 means none.
  int m_owner, m_hold, m_resume, m_rr_last, m_pre, m_to;
  logic [2:0] samp_req;

  mem_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .gnt(gnt),
    .accmodule(accmodule), .busy(busy),
    .nb_preempts(nb_preempts), .nb_timeouts(nb_timeouts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input logic [2:0] r);
    if (r[0]) return 0;
    if (m_resume >= 0 && r[m_resume]) return m_resume;
    if (r[1] && r[2]) return (m_rr_last == 2) ? 1 : 2;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0] oth;
    int nxt;
    bit fresh;
    if (reset) begin
      m_owner = -1; m_hold = 0; m_resume = -1; m_rr_last = 2; m_pre = 0; m_to = 0;
      return;
    end
    fresh = 1'b1;
    nxt   = m_owner;
    if (m_owner < 0 || done[m_owner] || !req[m_owner]) begin
      nxt = m_pick(req);
    end else if (m_owner != 0 && req[0]) begin
      nxt = 0;
      m_resume = m_owner;
      if (m_pre < SAT) m_pre++;
    end else begin
      oth = req;
      oth[m_owner] = 1'b0;
      if (m_hold == MAX_HOLD && oth != 3'b000) begin
        nxt = m_pick(oth);
        if (m_to < SAT) m_to++;
      end else begin
        fresh = 1'b0;
      end
    end
    if (fresh) begin
      m_owner = nxt;
      m_hold  = (nxt < 0) ? 0 : 1;
      if (nxt == 1 || nxt == 2) m_rr_last = nxt;
      if (nxt >= 0 && nxt == m_resume) m_resume = -1;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
    if (m_resume >= 0 && !req[m_resume]) m_resume = -1;
  endtask

  task automatic step();
    logic [2:0] exp_gnt;
    @(posedge clk);
    samp_req = req;
    model_step();
    #1;
    exp_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("accmodule", 32'(accmodule), 32'(m_owner + 1));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("nb_preempts", 32'(nb_preempts), 32'(m_pre));
    check("nb_timeouts", 32'(nb_timeouts), 32'(m_to));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("gnt_without_req", 32'(gnt & ~samp_req), 32'd0);
  endtask

  task automatic drive(input logic rst, input logic [2:0] r, input logic [2:0] d);
    reset = rst;
    req   = r;
    done  = d;
    step();
  endtask

  initial begin
    reset = 1'b1; req = 3'b000; done = 3'b000;

    // Reset state and single M2 transaction
    drive(1'b1, 3'b000, 3'b000);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cnt", 32'(nb_preempts) + 32'(nb_timeouts), 32'd0);
    drive(1'b0, 3'b010, 3'b000);
    check("t1_gnt", 32'(gnt), 32'b010);
    check("t1_acc", 32'(accmodule), 32'b10);
    drive(1'b0, 3'b010, 3'b000);
    drive(1'b0, 3'b000, 3'b010);
    check("t1_idle", 32'({gnt, busy}), 32'd0);

    // Round-robin alternation without idle gaps
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b110, 3'b000);
    check("t2_first", 32'(gnt), 32'b010);
    drive(1'b0, 3'b110, 3'b010);
    check("t2_m3", 32'(gnt), 32'b100);
    drive(1'b0, 3'b110, 3'b100);
    check("t2_m2", 32'(gnt), 32'b010);
    drive(1'b0, 3'b110, 3'b010);
    check("t2_m3b", 32'(gnt), 32'b100);
    check("t2_cnt", 32'(nb_preempts) + 32'(nb_timeouts), 32'd0);

    // Preemption of M3, then resume beats round-robin, then reset during M1 grant
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b100, 3'b000);
    drive(1'b0, 3'b101, 3'b000);
    check("t3_pre_gnt", 32'(gnt), 32'b001);
    check("t3_pre_cnt", 32'(nb_preempts), 32'd1);
    drive(1'b0, 3'b110, 3'b001);
    check("t3_resume", 32'(gnt), 32'b100);
    drive(1'b0, 3'b101, 3'b000);
    check("t3_pre2", 32'(nb_preempts), 32'd2);
    drive(1'b1, 3'b001, 3'b000);
    check("t3_rst_gnt", 32'(gnt), 32'd0);
    check("t3_rst_cnt", 32'(nb_preempts), 32'd0);

    // Hold-limit timeout, then indefinite hold with no contention
    drive(1'b0, 3'b000, 3'b000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      drive(1'b0, 3'b110, 3'b000);
      check("t4_hold", 32'(gnt), 32'b010);
    end
    drive(1'b0, 3'b110, 3'b000);
    check("t4_to_gnt", 32'(gnt), 32'b100);
    check("t4_to_cnt", 32'(nb_timeouts), 32'd1);
    drive(1'b0, 3'b010, 3'b000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3'b010, 3'b000);
      check("t4_long", 32'({gnt, nb_timeouts}), 32'({3'b010, 4'd1}));
    end

    // done coinciding with M1 request is a normal release
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b010, 3'b000);
    drive(1'b0, 3'b011, 3'b010);
    check("t5_gnt", 32'(gnt), 32'b001);
    check("t5_cnt", 32'(nb_preempts), 32'd0);

    // Counter saturation
    drive(1'b1, 3'b000, 3'b000);
    for (int i = 0; i < SAT + 3; i++) begin
      drive(1'b0, 3'b010, 3'b000);
      drive(1'b0, 3'b011, 3'b000);
    end
    check("sat_pre", 32'(nb_preempts), 32'(SAT));

    // Randomized traffic with sticky requests
    drive(1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] r, d;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 3'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      drive(($urandom_range(0, 299) == 0), r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
